// File: rtl/i2c_tx.sv
// i2c_tx: write-only I2C controller: START, 7-bit address + W, N data bytes with ACK
// checks, STOP, on open-drain SCL/SDA with target clock stretching.
module i2c_tx #(
  parameter int QUARTER = 63
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda
);
  localparam int QW = $clog2(QUARTER);
  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, LOAD, DATA, DACK, STOP} state_t;
  state_t state;
  logic [QW-1:0] qc;
  logic [1:0] ph;
  logic [2:0] bc;
  logic [7:0] sh;
  logic last, nack_f, samp, scl_oe, sda_oe, scl_m, scl_s, sda_m, sda_s;
  logic run, stall, qend, bit_end, clk_st;
  assign i2c_scl = scl_oe ? 1'b0 : 1'bz;
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
  assign run = (state != IDLE) && (state != LOAD);
  assign clk_st = state inside {ADDR, AACK, DATA, DACK, STOP};
  // the quarter counter waits at the start of q2 until the released SCL is seen high
  assign stall = (ph == 2'd2) && (qc == '0) && !scl_s;
  assign qend = qc == QW'(QUARTER - 1);
  assign bit_end = qend && (ph == 2'd3);
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      qc <= '0;
      ph <= '0;
      bc <= '0;
      sh <= '0;
      last <= 1'b0;
      nack_f <= 1'b0;
      samp <= 1'b1;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      {scl_s, scl_m, sda_s, sda_m} <= 4'hf;
      tx_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
    end else begin
      {scl_s, scl_m} <= {scl_m, i2c_scl};
      {sda_s, sda_m} <= {sda_m, i2c_sda};
      tx_ready <= 1'b0;
      done <= 1'b0;
      if (run && !stall) begin
        qc <= qend ? '0 : qc + QW'(1);
        if (qend) ph <= ph + 2'd1;
      end
      if (ph == 2'd3 && qc == '0) samp <= sda_s;
      if (clk_st && qend && ph == 2'd1) scl_oe <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          sh <= {addr, 1'b0};
          busy <= 1'b1;
          nack <= 1'b0;
          nack_f <= 1'b0;
          sda_oe <= 1'b1;
          state <= START;
        end
        START: if (qend && ph == 2'd1) begin
          ph <= '0;
          scl_oe <= 1'b1;
          sda_oe <= ~sh[7];
          state <= ADDR;
        end
        ADDR, DATA: if (bit_end) begin
          scl_oe <= 1'b1;
          bc <= bc + 3'd1;
          sh <= sh << 1;
          sda_oe <= (bc == 3'd7) ? 1'b0 : ~sh[6];
          if (bc == 3'd7) state <= (state == ADDR) ? AACK : DACK;
        end
        AACK: if (bit_end) begin
          scl_oe <= 1'b1;
          sda_oe <= samp;
          nack_f <= samp;
          state <= samp ? STOP : LOAD;
        end
        LOAD: if (tx_valid) begin
          sh <= tx_data;
          last <= tx_last;
          tx_ready <= 1'b1;
          sda_oe <= ~tx_data[7];
          state <= DATA;
        end
        DACK: if (bit_end) begin
          scl_oe <= 1'b1;
          sda_oe <= samp | last;
          nack_f <= samp;
          state <= (samp || last) ? STOP : LOAD;
        end
        STOP: begin
          if (qend && ph == 2'd2) sda_oe <= 1'b0;
          // q3 runs twice: two quarters of bus-free time after SDA rises
          if (bit_end) begin
            if (bc[0]) begin
              state <= IDLE;
              bc <= '0;
              done <= 1'b1;
              nack <= nack_f;
              busy <= 1'b0;
            end else begin
              bc <= 3'd1;
              ph <= 2'd3;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_tx.sv
// tb_i2c_tx: randomized bench for i2c_tx against a pulled-up bus with a behavioural
// responder that decodes START/STOP/bytes and ACKs, NACKs or stretches on request.
`timescale 1ns/1ps
module tb_i2c_tx;
  localparam int Q = 4;
  localparam int TMO = 4000;
  logic sys_clk = 1'b0, rst_n = 1'b0, start = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] tx_data = '0;
  logic tx_ready, busy, done, nack;
  wire scl, sda;
  logic r_scl = 1'b0, r_sda = 1'b0;
  pullup (scl);
  pullup (sda);
  assign scl = r_scl ? 1'b0 : 1'bz;
  assign sda = r_sda ? 1'b0 : 1'bz;
  i2c_tx #(.QUARTER(Q)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .addr(addr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy), .done(done),
    .nack(nack), .i2c_scl(scl), .i2c_sda(sda)
  );
  always #5 sys_clk = ~sys_clk;
  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  int cyc = 0, starts, stops, rises, n_ready, n_done, bitn, byte_idx, hold, fall_t, rise_t;
  int st_low, st_high, st_state;
  int nack_at = 99, st_byte = -1, st_bit = 0;
  logic [7:0] cur;
  logic [7:0] got_b[$];
  logic got_a[$];
  logic scl_p = 1'b1, sda_p = 1'b1, mon_clr = 1'b0;
  logic [7:0] dq[$];
  initial forever begin
    logic s_scl, s_sda;
    @(negedge sys_clk);
    s_scl = scl;
    s_sda = sda;
    cyc++;
    if (mon_clr) begin
      starts = 0; stops = 0; rises = 0; n_ready = 0; n_done = 0; bitn = 0; byte_idx = 0;
      hold = 0; st_state = 0; st_low = 0; st_high = 0; r_scl = 1'b0; r_sda = 1'b0;
      got_b.delete();
      got_a.delete();
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) r_scl = 1'b0;
      end
      if (tx_ready) n_ready++;
      if (done) n_done++;
      if (scl_p && s_scl && sda_p && !s_sda) begin
        starts++; bitn = 0; byte_idx = 0;
      end else if (scl_p && s_scl && !sda_p && s_sda) begin
        stops++; bitn = 0;
      end else if (!scl_p && s_scl) begin
        rises++;
        if (st_state == 1) begin st_low = cyc - fall_t; st_state = 2; end
        rise_t = cyc;
        if (bitn < 8) begin
          cur = {cur[6:0], s_sda};
          bitn++;
        end else begin
          got_b.push_back(cur);
          got_a.push_back(s_sda);
          byte_idx++;
          bitn = 0;
        end
      end else if (scl_p && !s_scl) begin
        if (st_state == 2) begin st_high = cyc - rise_t; st_state = 3; end
        fall_t = cyc;
        r_sda = (bitn == 8) && (byte_idx != nack_at);
        if (st_state == 0 && byte_idx == st_byte && bitn == st_bit) begin
          hold = 20; r_scl = 1'b1; st_state = 1;
        end
      end
    end
    scl_p = s_scl;
    sda_p = s_sda;
  end
  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge sys_clk); #1;
    mon_clr = 1'b0;
  endtask
  task automatic fill_rand(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
  endtask
  // nk: index of the first bus byte the responder NACKs (0 = address); >= n+1 means all ACKed
  task automatic run_txn(input logic [6:0] a, input int nk, input int sb, input int sbit,
                         input int wait_c, input bit dbl);
    logic [7:0] d[$];
    logic [7:0] expb[$];
    int n, e, busy_low;
    logic got_done, got_nack;
    d = dq;
    n = d.size();
    nack_at = nk;
    st_byte = sb;
    st_bit = sbit;
    e = (nk < n + 1) ? nk + 1 : n + 1;
    expb.push_back({a, 1'b0});
    for (int i = 0; i < e - 1; i++) expb.push_back(d[i]);
    clear_mon();
    addr = a;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("busy_on_start", busy, 1);
    busy_low = 0;
    fork
      begin
        int k, t, bad;
        bit fin;
        logic sd;
        k = 0;
        fin = 0;
        while (k < n && !fin) begin
          if (k == 0 && wait_c > 0) begin
            t = 0;
            bad = 0;
            while ((byte_idx < 1 || scl) && t < TMO) begin @(posedge sys_clk); #1; t++; end
            repeat (2) begin @(posedge sys_clk); #1; end
            sd = sda;
            repeat (wait_c) begin
              @(posedge sys_clk); #1;
              if (!(scl == 1'b0 && sda == sd)) bad++;
            end
            check("load_bus_frozen", bad, 0);
          end
          tx_data = d[k];
          tx_last = (k == n - 1);
          tx_valid = 1'b1;
          t = 0;
          do begin @(posedge sys_clk); #1; t++; end while (!tx_ready && !done && t < TMO);
          if (k == 0 && wait_c > 0) check("tx_ready_latency", t, 1);
          if (tx_ready) k++;
          else fin = 1;
        end
        tx_valid = 1'b0;
        tx_last = 1'b0;
      end
      begin
        int t2;
        t2 = 0;
        while (!done && t2 < TMO) begin
          @(posedge sys_clk); #1;
          t2++;
          start = dbl && (t2 == 60);
          if (!busy && !done) busy_low++;
        end
        start = 1'b0;
        got_done = done;
        got_nack = nack;
      end
    join
    check("done_seen", got_done, 1);
    check("nack_with_done", got_nack, nk < n + 1);
    check("busy_held", busy_low, 0);
    repeat (40) begin @(posedge sys_clk); #1; end
    check("done_pulses", n_done, 1);
    check("busy_idle", busy, 0);
    check("nack_hold", nack, nk < n + 1);
    check("start_conds", starts, 1);
    check("stop_conds", stops, 1);
    check("bytes_on_bus", got_b.size(), e);
    for (int i = 0; i < e && i < got_b.size(); i++) begin
      check($sformatf("bus_byte%0d", i), got_b[i], expb[i]);
      check($sformatf("ack_bit%0d", i), got_a[i], i == nk);
    end
    check("tx_ready_pulses", n_ready, e - 1);
    check("scl_bit_clocks", rises - stops, 9 * e);
    if (sb >= 0) begin
      check("stretch_low", (st_low >= 20 && st_low <= 22), 1);
      check("stretch_high", (st_high >= 2 * Q && st_high <= 2 * Q + 3), 1);
    end
  endtask
  initial begin
    int t;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    dq = '{8'hA5, 8'h3C};
    run_txn(7'h50, 99, -1, 0, 0, 0);
    fill_rand(2);
    run_txn(7'h22, 0, -1, 0, 0, 0);
    fill_rand(3);
    run_txn(7'($urandom), 2, -1, 0, 0, 0);
    fill_rand(2);
    run_txn(7'($urandom), 99, 1, 3, 0, 0);
    fill_rand(2);
    run_txn(7'($urandom), 99, -1, 0, 50, 0);
    clear_mon();
    nack_at = 99;
    st_byte = -1;
    tx_data = 8'h00;
    tx_last = 1'b0;
    tx_valid = 1'b1;
    addr = 7'h3A;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    t = 0;
    while ((byte_idx < 1 || scl) && t < TMO) begin @(posedge sys_clk); #1; t++; end
    check("reach_data_byte", t < TMO, 1);
    repeat (2) begin @(posedge sys_clk); #1; end
    check("pre_rst_sda_low", sda, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    tx_valid = 1'b0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    fill_rand(2);
    run_txn(7'($urandom), 99, -1, 0, 0, 0);
    fill_rand(3);
    run_txn(7'($urandom), 99, -1, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      fill_rand($urandom_range(1, 4));
      run_txn(7'($urandom), $urandom_range(0, 6), -1, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
